// File: rtl/framebuffer_loader.sv
// Write-side loader for the dual-port framebuffer: decodes 'L' (row load) and 'F' (fill)
// commands from a valid/ready byte stream and drives the 8-bit framebuffer write port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a command byte
// GET_ROW  | 'L' seen, waiting for the row index
// GET_DATA | streaming ROW_BYTES data bytes into the latched row
// FILL_VAL | 'F' seen, waiting for the fill value
// FILL     | writing the fill value to every address, stream stalled
module framebuffer_loader #(
  parameter int ROW_BYTES      = 128,
  parameter int ROWS           = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [7:0]            RxData,
  input  logic                  RxValid,
  output logic                  RxReady,
  output logic [ADDR_WIDTH-1:0] AddressA,
  output logic [7:0]            DataInA,
  output logic                  WrA,
  output logic                  ClockEnA,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  localparam int COL_W = $clog2(ROW_BYTES);
  localparam int ROW_W = ADDR_WIDTH - COL_W;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      ROWS_U   = 32'(ROWS);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_FILL = 8'h46;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ROW,
    S_GET_DATA,
    S_FILL_VAL,
    S_FILL
  } state_t;

  state_t                  state_q, state_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [7:0]              fill_q, fill_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              data_q, data_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic                    tmo_hit;
  logic                    row_ok;
  logic [ADDR_WIDTH-1:0]   addr_inc;

  assign RxReady  = (state_q != S_FILL);
  assign accept   = RxValid & RxReady;
  assign tmo_hit  = (tmo_q == TMO_LAST);
  assign row_ok   = ({24'd0, RxData} < ROWS_U);
  assign addr_inc = addr_q + ADDR_WIDTH'(1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      tmo_q   <= '0;
      fill_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tmo_q   <= tmo_d;
      fill_q  <= fill_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Write-port outputs are registered from the next-state values, giving a
  // one-cycle write latency after each accepted data byte.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tmo_d   = '0;
    fill_d  = fill_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (RxData == CMD_LOAD) begin
            state_d = S_GET_ROW;
          end else if (RxData == CMD_FILL) begin
            state_d = S_FILL_VAL;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_GET_ROW: begin
        if (accept) begin
          if (row_ok) begin
            row_d   = ROW_W'(RxData);
            col_d   = '0;
            state_d = S_GET_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_GET_DATA: begin
        if (accept) begin
          wr_d   = 1'b1;
          addr_d = {row_q, col_q};
          data_d = RxData;
          col_d  = col_q + COL_W'(1);
          if (col_q == COL_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_FILL_VAL: begin
        if (accept) begin
          // The first fill write is issued on entry so FILL lasts exactly one
          // cycle per address and RxReady returns right after the final write.
          fill_d  = RxData;
          wr_d    = 1'b1;
          addr_d  = '0;
          data_d  = RxData;
          state_d = S_FILL;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_FILL: begin
        if (&addr_q) begin
          state_d = S_IDLE;
        end else begin
          wr_d   = 1'b1;
          addr_d = addr_inc;
          data_d = fill_q;
          done_d = &addr_inc;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign AddressA = addr_q;
  assign DataInA  = data_q;
  assign WrA      = wr_q;
  assign ClockEnA = wr_q;
  assign Busy     = (state_q != S_IDLE);
  assign Done     = done_q;
  assign Error    = err_q;

endmodule

// File: tb/tb_framebuffer_loader.sv
// Scoreboard bench for framebuffer_loader: expected writes are queued at stimulus time and
// compared against writes captured by a negedge monitor.
module tb_framebuffer_loader;

  localparam int AW  = 12;
  localparam int TMO = 100;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [7:0]    RxData;
  logic          RxValid;
  logic          RxReady;
  logic [AW-1:0] AddressA;
  logic [7:0]    DataInA;
  logic          WrA;
  logic          ClockEnA;
  logic          Busy;
  logic          Done;
  logic          Error;

  framebuffer_loader #(
    .ROW_BYTES(128),
    .ROWS(32),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .RxData(RxData),
    .RxValid(RxValid),
    .RxReady(RxReady),
    .AddressA(AddressA),
    .DataInA(DataInA),
    .WrA(WrA),
    .ClockEnA(ClockEnA),
    .Busy(Busy),
    .Done(Done),
    .Error(Error)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic mon_on = 1'b0;

  // {address, data, done}
  logic [20:0] exp_q[$];
  logic [20:0] obs_q[$];
  int err_count = 0;
  int done_count = 0;
  int ce_bad = 0;
  int both_bad = 0;
  int done_nowr = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (mon_on) begin
      if (WrA === 1'b1) obs_q.push_back({AddressA, DataInA, Done});
      if (ClockEnA !== WrA) ce_bad <= ce_bad + 1;
      if (Done === 1'b1 && Error === 1'b1) both_bad <= both_bad + 1;
      if (Done === 1'b1 && WrA !== 1'b1) done_nowr <= done_nowr + 1;
      if (Error === 1'b1) err_count <= err_count + 1;
      if (Done === 1'b1) done_count <= done_count + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1);
  end

  // Entered and left just after a falling edge; the byte transfers on the rising edge between.
  task automatic send_byte(input logic [7:0] b);
    int budget;
    budget = 0;
    RxData  = b;
    RxValid = 1'b1;
    while (RxReady !== 1'b1 && budget < 10000) begin
      @(negedge Clock);
      budget++;
    end
    if (RxReady !== 1'b1) begin
      n_err++;
      $display("FAIL send_stall: RxReady=%b for byte %h, required 1", RxReady, b);
    end
    @(negedge Clock);
    RxValid = 1'b0;
  endtask

  task automatic load_row(input logic [7:0] row, input int nbytes, input int gap, input logic [7:0] base);
    for (int i = 0; i < nbytes; i++)
      exp_q.push_back({12'(int'(row) * 128 + i), 8'(int'(base) + i), (i == 127)});
    send_byte(8'h4C);
    send_byte(row);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(8'(int'(base) + i));
      repeat (gap) @(negedge Clock);
    end
  endtask

  task automatic test_reset();
    Reset   = 1'b1;
    RxValid = 1'b0;
    RxData  = 8'h00;
    repeat (3) @(negedge Clock);
    n_vec++;
    if ({WrA, ClockEnA, Done, Error, Busy, RxReady, AddressA, DataInA} !== {5'b0, 1'b1, 12'h000, 8'h00}) begin
      n_err++;
      $display("FAIL reset_outputs: wr=%b ce=%b done=%b err=%b busy=%b rdy=%b addr=%h data=%h, required 0/0/0/0/0/1/000/00",
               WrA, ClockEnA, Done, Error, Busy, RxReady, AddressA, DataInA);
    end
    Reset  = 1'b0;
    mon_on = 1'b1;
    @(negedge Clock);
    n_vec++;
    if (RxReady !== 1'b1 || Busy !== 1'b0 || WrA !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: rdy=%b busy=%b wr=%b, required 1/0/0", RxReady, Busy, WrA);
    end
  endtask

  task automatic test_row_load();
    logic [20:0] e, o;
    int d0, e0;
    d0 = done_count;
    e0 = err_count;
    for (int i = 0; i < 128; i++) exp_q.push_back({12'(12'h180 + i), 8'(i), (i == 127)});
    send_byte(8'h4C);
    send_byte(8'h03);
    for (int i = 0; i < 128; i++) begin
      send_byte(8'(i));
      n_vec++;
      if (WrA !== 1'b1 || AddressA !== 12'(12'h180 + i)) begin
        n_err++;
        $display("FAIL row3_latency: byte %0d wr=%b addr=%h, required 1 addr=%h", i, WrA, AddressA, 12'(12'h180 + i));
      end
    end
    repeat (3) @(negedge Clock);
    n_vec++;
    if (obs_q.size() != 128) begin
      n_err++;
      $display("FAIL row3_count: %0d writes, required 128", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL row3_write: addr=%h data=%h done=%b, required addr=%h data=%h done=%b",
                 o[20:9], o[8:1], o[0], e[20:9], e[8:1], e[0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
    n_vec++;
    if (done_count - d0 != 1 || err_count != e0 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL row3_flags: done_pulses=%0d err_pulses=%0d busy=%b, required 1/0/0",
               done_count - d0, err_count - e0, Busy);
    end
  endtask

  task automatic test_gapped_row();
    logic [20:0] e, o;
    int d0, e0;
    d0 = done_count;
    e0 = err_count;
    load_row(8'h03, 128, 5, 8'h00);
    repeat (3) @(negedge Clock);
    n_vec++;
    if (obs_q.size() != 128) begin
      n_err++;
      $display("FAIL gapped_count: %0d writes, required 128", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL gapped_write: addr=%h data=%h done=%b, required addr=%h data=%h done=%b",
                 o[20:9], o[8:1], o[0], e[20:9], e[8:1], e[0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
    n_vec++;
    if (done_count - d0 != 1 || err_count != e0) begin
      n_err++;
      $display("FAIL gapped_flags: done_pulses=%0d err_pulses=%0d, required 1/0", done_count - d0, err_count - e0);
    end
  endtask

  task automatic test_fill();
    logic [20:0] e, o;
    int d0, e0, low_cnt;
    logic seen_done;
    d0 = done_count;
    e0 = err_count;
    for (int i = 0; i < 4096; i++) exp_q.push_back({12'(i), 8'hA5, (i == 4095)});
    send_byte(8'h46);
    send_byte(8'hA5);
    // Hold a would-be error byte on the stream for the whole fill.
    RxData    = 8'h5A;
    RxValid   = 1'b1;
    low_cnt   = 0;
    seen_done = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (RxReady === 1'b0) low_cnt++;
      if (Done === 1'b1) begin
        seen_done = 1'b1;
        RxValid   = 1'b0;
        break;
      end
      @(negedge Clock);
    end
    RxValid = 1'b0;
    @(negedge Clock);
    n_vec++;
    if (seen_done !== 1'b1 || low_cnt != 4096) begin
      n_err++;
      $display("FAIL fill_ready_low: done_seen=%b ready_low_cycles=%0d, required 1/4096", seen_done, low_cnt);
    end
    n_vec++;
    if (RxReady !== 1'b1 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL fill_end: rdy=%b busy=%b, required 1/0", RxReady, Busy);
    end
    repeat (2) @(negedge Clock);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL fill_write: addr=%h data=%h done=%b, required addr=%h data=%h done=%b",
                 o[20:9], o[8:1], o[0], e[20:9], e[8:1], e[0]);
      end
    end
    n_vec++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_err++;
      $display("FAIL fill_count: %0d expected left, %0d extra writes, required 0/0", exp_q.size(), obs_q.size());
    end
    exp_q.delete();
    obs_q.delete();
    n_vec++;
    if (done_count - d0 != 1 || err_count != e0) begin
      n_err++;
      $display("FAIL fill_flags: done_pulses=%0d err_pulses=%0d, required 1/0", done_count - d0, err_count - e0);
    end
  endtask

  task automatic test_bad_cmd();
    send_byte(8'h5A);
    n_vec++;
    if (Error !== 1'b1 || WrA !== 1'b0 || Done !== 1'b0) begin
      n_err++;
      $display("FAIL bad_cmd: err=%b wr=%b done=%b, required 1/0/0", Error, WrA, Done);
    end
    repeat (2) @(negedge Clock);
    n_vec++;
    if (Busy !== 1'b0 || Error !== 1'b0 || obs_q.size() != 0) begin
      n_err++;
      $display("FAIL bad_cmd_after: busy=%b err=%b writes=%0d, required 0/0/0", Busy, Error, obs_q.size());
    end
  endtask

  task automatic test_bad_row();
    int e0, found;
    send_byte(8'h4C);
    n_vec++;
    if (Busy !== 1'b1) begin
      n_err++;
      $display("FAIL bad_row_busy: busy=%b after L, required 1", Busy);
    end
    send_byte(8'h20);
    n_vec++;
    if (Error !== 1'b1 || Busy !== 1'b0 || WrA !== 1'b0) begin
      n_err++;
      $display("FAIL bad_row: err=%b busy=%b wr=%b, required 1/0/0", Error, Busy, WrA);
    end
    @(negedge Clock);
    // Row 31 is the last legal row; with no data it must time out rather than error at once.
    e0 = err_count;
    send_byte(8'h4C);
    send_byte(8'h1F);
    n_vec++;
    if (Error !== 1'b0 || Busy !== 1'b1) begin
      n_err++;
      $display("FAIL row31_accept: err=%b busy=%b, required 0/1", Error, Busy);
    end
    found = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge Clock);
      if (Error === 1'b1) begin
        found = 1;
        break;
      end
    end
    @(negedge Clock);
    n_vec++;
    if (found != 1 || Busy !== 1'b0 || obs_q.size() != 0 || err_count - e0 != 1) begin
      n_err++;
      $display("FAIL row31_timeout: err_seen=%0d busy=%b writes=%0d err_pulses=%0d, required 1/0/0/1",
               found, Busy, obs_q.size(), err_count - e0);
    end
  endtask

  task automatic test_timeout();
    logic [20:0] e, o;
    int d0, c0, err_at, found;
    d0 = done_count;
    for (int i = 0; i < 10; i++) exp_q.push_back({12'(12'h080 + i), 8'(8'h30 + i), 1'b0});
    send_byte(8'h4C);
    send_byte(8'h01);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h30 + i));
    c0     = cyc;
    found  = 0;
    err_at = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge Clock);
      if (Error === 1'b1) begin
        found  = 1;
        err_at = cyc;
        break;
      end
    end
    n_vec++;
    if (found != 1 || err_at - c0 != TMO) begin
      n_err++;
      $display("FAIL timeout_latency: err_seen=%0d cycles_after_accept=%0d, required 1/%0d", found, err_at - c0, TMO);
    end
    repeat (2) @(negedge Clock);
    n_vec++;
    if (Busy !== 1'b0 || done_count != d0) begin
      n_err++;
      $display("FAIL timeout_state: busy=%b done_pulses=%0d, required 0/0", Busy, done_count - d0);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL timeout_write: addr=%h data=%h done=%b, required addr=%h data=%h done=%b",
                 o[20:9], o[8:1], o[0], e[20:9], e[8:1], e[0]);
      end
    end
    n_vec++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_err++;
      $display("FAIL timeout_count: %0d expected left, %0d extra writes, required 0/0", exp_q.size(), obs_q.size());
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid_row();
    logic [20:0] e, o;
    int d0, e0;
    d0 = done_count;
    e0 = err_count;
    load_row(8'h05, 40, 0, 8'h00);
    Reset = 1'b1;
    @(negedge Clock);
    n_vec++;
    if ({WrA, ClockEnA, Done, Error, Busy, RxReady, AddressA, DataInA} !== {5'b0, 1'b1, 12'h000, 8'h00}) begin
      n_err++;
      $display("FAIL mid_reset_outputs: wr=%b ce=%b done=%b err=%b busy=%b rdy=%b addr=%h data=%h, required 0/0/0/0/0/1/000/00",
               WrA, ClockEnA, Done, Error, Busy, RxReady, AddressA, DataInA);
    end
    Reset = 1'b0;
    @(negedge Clock);
    n_vec++;
    if (RxReady !== 1'b1 || done_count != d0 || err_count != e0) begin
      n_err++;
      $display("FAIL mid_reset_release: rdy=%b done_pulses=%0d err_pulses=%0d, required 1/0/0",
               RxReady, done_count - d0, err_count - e0);
    end
    load_row(8'h00, 128, 0, 8'h80);
    repeat (3) @(negedge Clock);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL mid_reset_write: addr=%h data=%h done=%b, required addr=%h data=%h done=%b",
                 o[20:9], o[8:1], o[0], e[20:9], e[8:1], e[0]);
      end
    end
    n_vec++;
    if (exp_q.size() != 0 || obs_q.size() != 0 || done_count - d0 != 1 || err_count != e0) begin
      n_err++;
      $display("FAIL mid_reset_reload: exp_left=%0d extra=%0d done_pulses=%0d err_pulses=%0d, required 0/0/1/0",
               exp_q.size(), obs_q.size(), done_count - d0, err_count - e0);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_signal_rules();
    n_vec++;
    if (ce_bad != 0 || both_bad != 0 || done_nowr != 0) begin
      n_err++;
      $display("FAIL signal_rules: ce_ne_wr=%0d done_and_err=%0d done_without_wr=%0d, required 0/0/0",
               ce_bad, both_bad, done_nowr);
    end
  endtask

  initial begin
    Reset   = 1'b1;
    RxValid = 1'b0;
    RxData  = 8'h00;
    @(negedge Clock);
    test_reset();
    test_row_load();
    test_gapped_row();
    test_fill();
    test_bad_cmd();
    test_bad_row();
    test_timeout();
    test_reset_mid_row();
    test_signal_rules();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/framebuffer_loader.md
Name: framebuffer_loader

Overview:
- Upstream write-side controller for the dual-port framebuffer.
- Consumes a byte stream (UART receiver output, valid/ready) carrying row-load and fill commands.
- Drives the framebuffer's 8-bit write port: address, data, write enable, clock enable.
- The display side reads the same memory independently through the 16-bit port; this block never touches it.

Parameters:
- ROW_BYTES, 128: bytes per panel row (64 px × 16-bit); must be a power of 2.
- ROWS, 32: panel rows; ROWS*ROW_BYTES must equal 2^ADDR_WIDTH.
- ADDR_WIDTH, 12: byte address width of the framebuffer write port.
- TIMEOUT_CYCLES, 65535: idle cycles allowed mid-packet before abort; ≥ 1.

Ports:
- Clock  in  1  single clock; framebuffer write port also runs on it.
- Reset  in  1  synchronous, active-high.
- RxData  in  8  stream byte.
- RxValid  in  1  RxData valid.
- RxReady  out  1  loader can accept; byte transfers when RxValid & RxReady at rising edge.
- AddressA  out  ADDR_WIDTH  framebuffer byte address.
- DataInA  out  8  framebuffer write data.
- WrA  out  1  write strobe, one byte per cycle.
- ClockEnA  out  1  equals WrA.
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  one-cycle pulse coincident with the last write of a row load or fill.
- Error  out  1  one-cycle pulse on protocol error or timeout.

Behaviour:
- Reset: state IDLE; WrA, ClockEnA, Done, Error, Busy = 0; AddressA, DataInA = 0; RxReady = 1 on the first cycle after reset; col, row and timeout counters = 0.
- Reset mid-operation: the packet is abandoned; bytes already written stay in memory; no Done/Error.
- State IDLE, accepted byte:
  - 0x4C ('L') → GET_ROW.
  - 0x46 ('F') → FILL_VAL.
  - any other value → Error pulse next cycle, stay IDLE.
- State GET_ROW, accepted byte r:
  - r < ROWS → latch row = r, col = 0 → GET_DATA.
  - r ≥ ROWS → Error pulse, → IDLE.
- State GET_DATA, accepted byte d:
  - Next cycle: WrA = ClockEnA = 1, AddressA = {row, col}, i.e. row*ROW_BYTES + col; DataInA = d. Write latency is 1 cycle after acceptance.
  - col increments; back-to-back accepts give back-to-back writes.
  - On acceptance of byte ROW_BYTES-1 (col wraps to 0): → IDLE; Done asserted in the same cycle as that final WrA.
- State FILL_VAL, accepted byte v: latch v, address counter = 0 → FILL.
- State FILL:
  - RxReady = 0.
  - WrA = 1 every cycle with AddressA = 0, 1, …, 2^ADDR_WIDTH-1 and DataInA = v; exactly 2^ADDR_WIDTH cycles.
  - Done pulses with the final write (address all-ones), then → IDLE.
  - RxReady returns to 1 on the cycle after Done.
- RxReady = 1 in IDLE, GET_ROW, GET_DATA and FILL_VAL; 0 in FILL.
- Timeout:
  - In GET_ROW, GET_DATA and FILL_VAL, the counter clears on each accepted byte and on state entry, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: Error pulse, → IDLE, partial row left as written.
- WrA is low on every cycle not listed above.
- Done and Error never assert in the same cycle.

Test Plan:
- Row load, row 3: stream 'L', 0x03, then bytes 0x00..0x7F back-to-back → 128 consecutive writes at AddressA 0x180..0x1FF with DataInA = 0x00..0x7F; Done coincides with the write to 0x1FF; Error stays 0.
- Gapped row load: same as above with RxValid deasserted 5 cycles between every byte → identical address/data sequence; no extra WrA; Done once.
- Fill: 'F', 0xA5 → RxReady 0 for 4096 cycles; writes 0x000..0xFFF, all 0xA5; Done on the 0xFFF write; RxValid held high during FILL transfers nothing.
- Errors: 'Z' in IDLE → Error pulse, no write. 'L', 0x20 → Error, no write, Busy drops. 'L', 0x01, 10 data bytes, then silence with TIMEOUT_CYCLES = 100 → Error exactly 100 cycles after the 10th accept; 10 writes at 0x080..0x089.
- Reset mid-row: 'L', 0x05, 40 bytes, assert Reset 1 cycle → all outputs 0, RxReady 1 after release; new 'L', 0x00 load completes normally with Done.
